// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared arbiter constants and one-hot/index helpers (used by noc_rr_arb, rr_pick)
package noc_arb_pkg;
  localparam int ARB_N_DEFAULT = 4;
  localparam int ARB_N_MAX = 32;
  function automatic logic [ARB_N_MAX-1:0] onehot(input int idx, input int n);
    logic [ARB_N_MAX-1:0] one;
    one = 1;
    return (idx >= 0 && idx < n) ? one << idx : '0;
  endfunction
  function automatic int onehot_to_idx(input logic [ARB_N_MAX-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < ARB_N_MAX; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner search; req/last in, found/idx out (ARB_FIXED_PRI_EN selects lowest-index-first)
module rr_pick import noc_arb_pkg::*; #(
  parameter int N = ARB_N_DEFAULT,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            found,
  output logic [IDXW-1:0] idx
);
  always_comb begin
    int k;
    found = 1'b0;
    idx = '0;
    k = 0;
`ifdef ARB_FIXED_PRI_EN
    for (int i = N - 1; i >= 0; i--) begin
      k = i;
      if (req[k]) begin
        found = 1'b1;
        idx = IDXW'(k);
      end
    end
`else
    // Walk offsets from farthest to nearest so the nearest set bit after last wins; last itself is offset N.
    for (int i = N; i >= 1; i--) begin
      k = (int'(last) + i) % N;
      if (req[k]) begin
        found = 1'b1;
        idx = IDXW'(k);
      end
    end
`endif
  end
endmodule

// File: rtl/noc_rr_arb.sv
// noc_rr_arb: registered N-way round-robin arbiter with packet lock; clk/reset(async high), req in; grant/grant_valid/grant_idx out; ARB_FIXED_PRI_EN selects fixed priority
module noc_rr_arb import noc_arb_pkg::*; #(
  parameter int N = ARB_N_DEFAULT,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx
);
  logic [N-1:0] grant_q;
  logic [IDXW-1:0] last_q;
  logic found;
  logic [IDXW-1:0] pick_idx;
  logic hold;
  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req(req),
    .last(last_q),
    .found(found),
    .idx(pick_idx)
  );
  assign grant = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx = IDXW'(onehot_to_idx(ARB_N_MAX'(grant_q)));
  assign hold = grant_valid && req[grant_idx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      last_q <= IDXW'(N - 1);
    end else if (!hold) begin
      grant_q <= found ? N'(onehot(int'(pick_idx), N)) : '0;
      if (found) last_q <= pick_idx;
    end
  end
endmodule

// File: tb/tb_noc_rr_arb.sv
// tb_noc_rr_arb: table-driven directed bench for noc_rr_arb
module tb_noc_rr_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic grant_valid;
  logic [1:0] grant_idx;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] rr;
    logic [3:0] fp;
  } vec_t;
  localparam int NV = 30;
  vec_t tbl [NV];
  noc_rr_arb #(.N(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check(input string nm, input logic [3:0] g);
    int ei;
    ei = 0;
    for (int i = 0; i < 4; i++) if (g[i]) ei = i;
    cmp({nm, ".grant"}, 32'(grant), 32'(g));
    cmp({nm, ".valid"}, 32'(grant_valid), 32'(|g));
    cmp({nm, ".idx"}, 32'(grant_idx), 32'(ei));
  endtask
  task automatic step(input string nm, input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
    check(nm, g);
    cmp({nm, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
    cmp({nm, ".req_cover"}, 32'(grant & ~r), 32'd0);
  endtask
  initial begin
    tbl = '{
      {4'b0000, 4'b0000, 4'b0000}, {4'b0000, 4'b0000, 4'b0000}, {4'b0000, 4'b0000, 4'b0000},
      {4'b0000, 4'b0000, 4'b0000}, {4'b0000, 4'b0000, 4'b0000},
      {4'b0001, 4'b0001, 4'b0001}, {4'b0001, 4'b0001, 4'b0001}, {4'b0001, 4'b0001, 4'b0001},
      {4'b0001, 4'b0001, 4'b0001}, {4'b0001, 4'b0001, 4'b0001}, {4'b0001, 4'b0001, 4'b0001},
      {4'b1111, 4'b0001, 4'b0001}, {4'b1111, 4'b0001, 4'b0001},
      {4'b1110, 4'b0010, 4'b0010}, {4'b1101, 4'b0100, 4'b0001}, {4'b1011, 4'b1000, 4'b0001},
      {4'b0111, 4'b0001, 4'b0001},
      {4'b1111, 4'b0001, 4'b0001}, {4'b1110, 4'b0010, 4'b0010}, {4'b1111, 4'b0010, 4'b0010},
      {4'b1001, 4'b1000, 4'b0001}, {4'b0011, 4'b0001, 4'b0001}, {4'b0000, 4'b0000, 4'b0000},
      {4'b0100, 4'b0100, 4'b0100}, {4'b0000, 4'b0000, 4'b0000}, {4'b0100, 4'b0100, 4'b0100},
      {4'b0000, 4'b0000, 4'b0000},
      {4'b1011, 4'b1000, 4'b0001}, {4'b0011, 4'b0001, 4'b0001}, {4'b0110, 4'b0010, 4'b0010}
    };
    repeat (2) @(posedge clk);
    #1;
    check("in_reset", 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
`ifdef ARB_FIXED_PRI_EN
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].fp);
`else
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].rr);
`endif
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", 4'b0000);
    #1;
    reset = 1'b0;
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("after_reset", 4'b0001);
    step("after_reset_hold", 4'b1111, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_rr_arb.md
Name: noc_rr_arb

Overview:
- Registered N-way round-robin arbiter with grant lock.
- Sits in the NOC switch (ps) between the per-perm-device p2n response FIFOs and the single NOC return port.
- The one-hot grant drives the return-port mux and FIFO read enables.
- A grant is held for the whole packet, i.e. while the winner keeps its request high.

Parameters:
- N, 4, number of requesters (N >= 2).
- IDXW, $clog2(N), width of the grant index output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous and active-high.
- req  in  N  request vector; bit i high while requester i wants, or still owns, the port.
- grant  out  N  registered grant; one-hot or all-zero.
- grant_valid  out  1  OR-reduction of grant.
- grant_idx  out  IDXW  binary index of the set grant bit; 0 when grant_valid=0.

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-high.
  - reset=1 clears immediately, without waiting for clk: grant=0, grant_valid=0, grant_idx=0, last_q=N-1 (so requester 0 has top priority first).
  - Reset asserted mid-grant drops the grant at once. After release, arbitration restarts from requester 0.
- Internal state:
  - grant_q: N bits, drives grant directly.
  - last_q: IDXW bits, index of the most recent winner.
- Each posedge clk, not in reset:
  - Hold: grant_q != 0 and req[grant_idx]=1 -> grant_q and last_q unchanged, regardless of the other requests (packet lock).
  - Re-arbitrate: grant_q == 0, or req[grant_idx]=0.
    - Scan indices last_q+1, last_q+2, ..., last_q+N, all modulo N; the previous winner is scanned last.
    - First index k with req[k]=1 -> grant_q <= onehot(k), last_q <= k.
    - No request -> grant_q <= 0, last_q unchanged.
- Latency and handover:
  - 1 cycle from a request rising (port idle) to grant.
  - When the holder drops req, the next grant appears on the following edge; there is no idle cycle between owners.
  - The holder dropping its req and another requester raising its req in the same cycle: the new requester is eligible on that same edge.
  - The dropped holder can win again only if no other req is set.
- Invariants:
  - grant is never multi-hot.
  - grant is never set for a bit whose req was 0 at the granting edge.
  - Outputs are purely registered, with no combinational req->grant path.
  - grant_valid and grant_idx are decoded combinationally from grant_q.
- X or undriven req bits are treated as 0 by the scan; the assertion checks this.

Optional Feature:
- Macro ARB_FIXED_PRI_EN.
- Defined: re-arbitration ignores last_q and always grants the lowest-index set req (fixed priority). The hold/lock rule is unchanged. last_q is still updated but unused.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package noc_arb_pkg holds:
  - ARB_N_DEFAULT = 4
  - function onehot(idx, N)
  - function onehot_to_idx
- Natural sub-module: rr_pick.
  - Purely combinational rotate / priority-encode / un-rotate.
  - Inputs: req, last_q. Outputs: found, idx.
  - The top holds only the registers and the hold/re-arbitrate mux.

Test Plan:
1. Reset, req=4'b0000 for 5 cycles -> grant=0000, grant_valid=0, grant_idx=0. Assert reset mid-grant (async, between edges) -> grant=0000 immediately. After release, req=1111 -> grant=0001.
2. req=0001 at cycle t -> grant=0001, grant_idx=0 from edge t+1. Hold req[0] 6 cycles, then raise req=1111 -> grant stays 0001 (lock).
3. From reset, req=1111 held; drop each winner's bit for one cycle on handover -> grant sequence 0001 -> 0010 -> 0100 -> 1000 -> 0001, each one edge after the drop, no 0000 gap.
4. Grant=0010 (last_q=1), drop req[1] with req=1001 -> grant=1000 (idx 3 beats idx 0). Then drop req[3] with req=0011 -> grant=0001.
5. Only requester 2 active: req 0100 -> 0000 -> 0100 -> grant 0100, then 0000, then 0100 again (one-cycle latency each).
6. With ARB_FIXED_PRI_EN defined, repeat scenario 3 -> the grant returns to 0001 after every handover while req[0]=1. With the macro undefined, scenario 3's rotation is required.
